dot_mac_unit: RTL and testbench

//  Pipelined multi-lane dot-product MAC; parametrised successor to the single-lane 8x8 MAC.

---
 rtl/dot_mac_unit.sv | 252 +++++++++++++++++++++++++
 tb/tb_dot_mac_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_mac_unit.sv
// dot_mac_unit: two-stage multi-lane dot-product MAC with valid/ready result port.
// Optional macro SATURATE_EN: clamp the accumulator on overflow instead of wrapping.
module dot_mac_unit #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic                    signed_mode,
    input  logic [LANES*DATA_W-1:0] a,
    input  logic [LANES*DATA_W-1:0] b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_data,
    output logic [CNT_W-1:0]        out_count,
    output logic                    out_overflow
);

    localparam int PW = 2 * DATA_W;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_PARTIAL,
        S_DONE
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;

    logic                       w_adv;
    logic                       w_accept;
    logic                       w_fire;
    logic                       w_mode;
    logic                       w_partial;

    logic                       r_in_first;
    logic                       r_in_mode;

    logic                       r_s1_valid;
    logic                       r_s1_last;
    logic                       r_s1_mode;
    logic [LANES-1:0][PW-1:0]   r_s1_prod;
    logic [LANES-1:0][PW-1:0]   w_prod;

    logic [LANES-1:0][ACC_W-1:0] w_ext;
    logic [ACC_W-1:0]           w_sum;
    logic [ACC_W-1:0]           w_base;
    logic [ACC_W:0]             w_wide;
    logic                       w_ovf;
    logic                       w_ovf_base;
    logic [ACC_W-1:0]           w_acc_nxt;
    logic [CNT_W-1:0]           w_cnt_base;
    logic [CNT_W-1:0]           w_cnt_nxt;

    logic [ACC_W-1:0]           r_acc;
    logic [CNT_W-1:0]           r_cnt;
    logic                       r_ovf;

    logic [ACC_W-1:0]           r_out_data;
    logic [CNT_W-1:0]           r_out_count;
    logic                       r_out_ovf;

`ifdef SATURATE_EN
    localparam logic [ACC_W-1:0] U_MAX = '1;
    localparam logic [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    logic                       r_sat;
    logic                       w_sat_base;
    logic                       w_sat_nxt;
`endif

    // Whole pipeline stalls only while a finished result is being held back.
    assign out_valid = (r_state == S_DONE);
    assign in_ready  = !(out_valid && !out_ready);
    assign w_adv     = in_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_fire    = r_s1_valid && w_adv;
    assign w_partial = (r_state == S_PARTIAL);

    // Mode is taken from the first beat and reused for the rest of the vector.
    assign w_mode = r_in_first ? signed_mode : r_in_mode;

    genvar gi;
    for (gi = 0; gi < LANES; gi++) begin : g_lane
        logic [DATA_W-1:0] w_a;
        logic [DATA_W-1:0] w_b;
        logic [PW-1:0]     w_ax;
        logic [PW-1:0]     w_bx;
        assign w_a  = a[gi*DATA_W +: DATA_W];
        assign w_b  = b[gi*DATA_W +: DATA_W];
        assign w_ax = w_mode ? PW'($signed(w_a)) : PW'(w_a);
        assign w_bx = w_mode ? PW'($signed(w_b)) : PW'(w_b);
        // Low PW bits of the extended product are the exact lane product.
        assign w_prod[gi] = w_ax * w_bx;
        assign w_ext[gi]  = r_s1_mode ? ACC_W'($signed(r_s1_prod[gi]))
                                      : ACC_W'(r_s1_prod[gi]);
    end

    // Adder tree over the extended lane products; fits ACC_W by construction.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sum = w_sum + w_ext[i];
        end
    end

    assign w_base     = w_partial ? r_acc : '0;
    assign w_cnt_base = w_partial ? r_cnt : '0;
    assign w_ovf_base = w_partial && r_ovf;
    assign w_cnt_nxt  = (&w_cnt_base) ? w_cnt_base : w_cnt_base + CNT_W'(1);

    assign w_wide = {r_s1_mode & w_base[ACC_W-1], w_base}
                  + {r_s1_mode & w_sum[ACC_W-1], w_sum};
    assign w_ovf  = r_s1_mode ? (w_wide[ACC_W] ^ w_wide[ACC_W-1])
                              : w_wide[ACC_W];

`ifdef SATURATE_EN
    assign w_sat_base = w_partial && r_sat;
`endif

    // Next accumulator value: wrap by default, clamp and pin when saturating.
    always_comb begin
        w_acc_nxt = w_wide[ACC_W-1:0];
`ifdef SATURATE_EN
        w_sat_nxt = w_sat_base;
        if (w_sat_base) begin
            w_acc_nxt = w_base;
        end else if (w_ovf) begin
            w_sat_nxt = 1'b1;
            if (!r_s1_mode) begin
                w_acc_nxt = U_MAX;
            end else if (w_wide[ACC_W]) begin
                w_acc_nxt = S_MIN;
            end else begin
                w_acc_nxt = S_MAX;
            end
        end
`endif
    end

    // Input-side tracking of vector start and the latched operand mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_first <= 1'b1;
            r_in_mode  <= 1'b0;
        end else if (w_accept) begin
            r_in_first <= in_last;
            if (r_in_first) begin
                r_in_mode <= signed_mode;
            end
        end
    end

    // S1: register lane products and beat tags on every pipeline advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_mode  <= 1'b0;
            r_s1_prod  <= '0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_last <= in_last;
                r_s1_mode <= w_mode;
                r_s1_prod <= w_prod;
            end
        end
    end

    // Accumulator state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accumulator next state: beats move toward DONE, a handshake drains it.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_EMPTY, S_PARTIAL: begin
                if (w_fire) begin
                    w_state_nxt = r_s1_last ? S_DONE : S_PARTIAL;
                end
            end
            S_DONE: begin
                if (w_fire) begin
                    w_state_nxt = r_s1_last ? S_DONE : S_PARTIAL;
                end else if (out_ready) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // S2: accumulate a beat, or clear everything when the vector completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_fire) begin
            if (r_s1_last) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else begin
                r_acc <= w_acc_nxt;
                r_cnt <= w_cnt_nxt;
                r_ovf <= w_ovf_base | w_ovf;
            end
        end
    end

`ifdef SATURATE_EN
    // Sticky clamp flag, held for the remainder of the vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sat <= 1'b0;
        end else if (w_fire) begin
            r_sat <= r_s1_last ? 1'b0 : w_sat_nxt;
        end
    end
`endif

    // Result registers load on the last beat and hold through backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_fire && r_s1_last) begin
            r_out_data  <= w_acc_nxt;
            r_out_count <= w_cnt_nxt;
            r_out_ovf   <= w_ovf_base | w_ovf;
        end
    end

    assign out_data     = r_out_data;
    assign out_count    = r_out_count;
    assign out_overflow = r_out_ovf;

endmodule

// File: tb/tb_dot_mac_unit.sv
// tb_dot_mac_unit: directed self-checking bench for dot_mac_unit (ACC_W=18).
// Expected values are hand-computed; SATURATE_EN selects clamped expectations.
module tb_dot_mac_unit;

    localparam int DW = 8;
    localparam int L  = 4;
    localparam int AW = 18;
    localparam int CW = 8;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic              signed_mode;
    logic [L*DW-1:0]   a;
    logic [L*DW-1:0]   b;
    logic              out_valid;
    logic              out_ready;
    logic [AW-1:0]     out_data;
    logic [CW-1:0]     out_count;
    logic              out_overflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [AW+CW:0] resq[$];

    dot_mac_unit #(
        .DATA_W(DW),
        .LANES (L),
        .ACC_W (AW),
        .CNT_W (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_last     (in_last),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_count   (out_count),
        .out_overflow(out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every completed output handshake.
    always @(posedge clk) begin
        if (!reset && out_valid && out_ready) begin
            resq.push_back({out_overflow, out_count, out_data});
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

    function automatic logic [31:0] pk(int l0, int l1, int l2, int l3);
        return {l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] av, input logic [31:0] bv,
                        input logic last, input logic mode);
        int  t;
        logic acc;
        t = 0;
        acc = 1'b0;
        a = av;
        b = bv;
        in_last = last;
        signed_mode = mode;
        in_valid = 1'b1;
        while (!acc && t < 50) begin
            #1 acc = in_ready;
            @(posedge clk);
            @(negedge clk);
            t++;
        end
        in_valid = 1'b0;
        n_cmp++;
        assert (acc === 1'b1) else begin
            n_err++;
            $error("FAIL accept: observed no accept expected accept");
        end
    endtask

    task automatic get_res(input string tag, input logic [AW-1:0] ed,
                           input logic [CW-1:0] ec, input logic eo);
        int t;
        logic [AW+CW:0] r;
        t = 0;
        while (resq.size() == 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        assert (resq.size() != 0) else begin
            n_err++;
            $error("FAIL %s_timeout: observed no result expected result", tag);
        end
        if (resq.size() != 0) begin
            r = resq.pop_front();
            chk({tag, "_data"}, 64'(r[AW-1:0]), 64'(ed));
            chk({tag, "_count"}, 64'(r[AW+CW-1:AW]), 64'(ec));
            chk({tag, "_ovf"}, 64'(r[AW+CW]), 64'(eo));
        end
    endtask

    initial begin
        logic [AW-1:0] e_uovf;
        logic [AW-1:0] e_sovf;
`ifdef SATURATE_EN
        e_uovf = 18'h3FFFF;
        e_sovf = 18'h1FFFF;
`else
        e_uovf = 18'h3F008;
        e_sovf = 18'h20000;
`endif
        reset = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        signed_mode = 1'b0;
        a = '0;
        b = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_count", 64'(out_count), 64'd0);
        chk("rst_ovf", 64'(out_overflow), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;
        @(negedge clk);

        // Unsigned single beat with latency check.
        send(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1'b1, 1'b0);
        chk("t1_lat1", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("t1_lat2", 64'(out_valid), 64'd1);
        get_res("t1", 18'd70, 8'd1, 1'b0);

        // Signed two-beat vector.
        send(pk(-1, 2, -3, 4), pk(1, 1, 1, 1), 1'b0, 1'b1);
        send(pk(-1, 2, -3, 4), pk(1, 1, 1, 1), 1'b1, 1'b1);
        get_res("t2", 18'd4, 8'd2, 1'b0);

        // Unsigned overflow.
        send(pk(255, 255, 255, 255), pk(255, 255, 255, 255), 1'b0, 1'b0);
        send(pk(255, 255, 255, 255), pk(255, 255, 255, 255), 1'b1, 1'b0);
        get_res("t4u", e_uovf, 8'd2, 1'b1);

        // Signed positive overflow.
        send(pk(-128, -128, -128, -128), pk(-128, -128, -128, -128), 1'b0, 1'b1);
        send(pk(-128, -128, -128, -128), pk(-128, -128, -128, -128), 1'b1, 1'b1);
        get_res("t4s", e_sovf, 8'd2, 1'b1);

        // Overflow flag clears for the next vector.
        send(pk(1, 1, 1, 1), pk(2, 2, 2, 2), 1'b1, 1'b0);
        get_res("t4c", 18'd8, 8'd1, 1'b0);

        // Backpressure: result held, input stalled, nothing lost.
        out_ready = 1'b0;
        send(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1'b1, 1'b0);
        send(pk(2, 2, 2, 2), pk(2, 2, 2, 2), 1'b1, 1'b0);
        a = pk(3, 3, 3, 3);
        b = pk(1, 1, 1, 1);
        in_last = 1'b1;
        signed_mode = 1'b0;
        in_valid = 1'b1;
        #1;
        chk("t3_stall_ready", 64'(in_ready), 64'd0);
        chk("t3_stall_valid", 64'(out_valid), 64'd1);
        chk("t3_stall_data0", 64'(out_data), 64'd70);
        repeat (3) @(negedge clk);
        chk("t3_hold_data", 64'(out_data), 64'd70);
        chk("t3_hold_count", 64'(out_count), 64'd1);
        chk("t3_hold_ready", 64'(in_ready), 64'd0);
        chk("t3_no_hs", 64'(resq.size()), 64'd0);
        out_ready = 1'b1;
        send(pk(3, 3, 3, 3), pk(1, 1, 1, 1), 1'b1, 1'b0);
        get_res("t3a", 18'd70, 8'd1, 1'b0);
        get_res("t3b", 18'd16, 8'd1, 1'b0);
        get_res("t3c", 18'd12, 8'd1, 1'b0);

        // Back-to-back single-beat vectors at full rate.
        send(pk(1, 0, 0, 0), pk(10, 0, 0, 0), 1'b1, 1'b0);
        send(pk(2, 0, 0, 0), pk(10, 0, 0, 0), 1'b1, 1'b0);
        send(pk(3, 0, 0, 0), pk(10, 0, 0, 0), 1'b1, 1'b0);
        get_res("b2b1", 18'd10, 8'd1, 1'b0);
        get_res("b2b2", 18'd20, 8'd1, 1'b0);
        get_res("b2b3", 18'd30, 8'd1, 1'b0);

        // Reset mid-vector drops the partial result.
        send(pk(5, 5, 5, 5), pk(5, 5, 5, 5), 1'b0, 1'b0);
        send(pk(5, 5, 5, 5), pk(5, 5, 5, 5), 1'b0, 1'b0);
        send(pk(5, 5, 5, 5), pk(5, 5, 5, 5), 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_rst_data", 64'(out_data), 64'd0);
        chk("t5_rst_valid", 64'(out_valid), 64'd0);
        chk("t5_rst_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        send(pk(1, 1, 1, 1), pk(1, 1, 1, 1), 1'b1, 1'b0);
        get_res("t5", 18'd4, 8'd1, 1'b0);

        // Mode toggled mid-vector is ignored; next vector relatches.
        send(pk(-1, -1, -1, -1), pk(1, 1, 1, 1), 1'b0, 1'b1);
        send(pk(-2, -2, -2, -2), pk(3, 3, 3, 3), 1'b1, 1'b0);
        get_res("t6", 18'h3FFE4, 8'd2, 1'b0);
        send(pk(-1, -1, -1, -1), pk(1, 1, 1, 1), 1'b1, 1'b0);
        get_res("t6u", 18'd1020, 8'd1, 1'b0);

        // Beat count saturates at 255.
        for (int i = 0; i < 299; i++) begin
            send(pk(0, 0, 0, 0), pk(0, 0, 0, 0), 1'b0, 1'b0);
        end
        send(pk(1, 0, 0, 0), pk(1, 0, 0, 0), 1'b1, 1'b0);
        get_res("cnt_sat", 18'd1, 8'd255, 1'b0);

        repeat (3) @(negedge clk);
        chk("end_empty", 64'(resq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
